cpec_bit_packer: RTL and testbench

CPEC_BIT_PACKER -- requirements
Module: cpec_bit_packer

---
 rtl/cpec_pkg.sv | 17 +
 rtl/cpec_bit_align.sv | 30 +++
 rtl/cpec_bit_packer.sv | 130 +++++++++++++
 tb/tb_cpec_bit_packer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpec_pkg.sv
// Shared CPEC constants, packer FSM state encoding and size-legality helper.
// No logic of its own; imported by the packer and its insert aligner.
// No flow control here.
package cpec_pkg;
    localparam int CPEC_DATA_W = 40;
    localparam int CPEC_SIZE_W = 6;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } cpec_state_t;

    // Sizes beyond the code width are treated as an empty beat.
    function automatic logic [CPEC_SIZE_W-1:0] cpec_eff_size(input logic [CPEC_SIZE_W-1:0] size);
        return (size > CPEC_SIZE_W'(CPEC_DATA_W)) ? '0 : size;
    endfunction
endpackage

// File: rtl/cpec_bit_align.sv
// Masks a right-aligned code to its size and places it just below the current fill.
// Latency: purely combinational.
// Backpressure: none; the caller only uses the result on an accepted beat.
module cpec_bit_align
    import cpec_pkg::*;
#(
    parameter int ACC_W  = 72,
    parameter int FILL_W = 7
) (
    input  logic [CPEC_DATA_W-1:0] in_data,
    input  logic [CPEC_SIZE_W-1:0] in_size,
    input  logic [FILL_W-1:0]      fill,
    output logic [ACC_W-1:0]       aligned
);

    logic [CPEC_DATA_W-1:0] mask;
    logic [CPEC_DATA_W-1:0] masked;
    logic [CPEC_SIZE_W-1:0] lshift;
    logic [ACC_W-1:0]       top;

    always_comb begin
        // Inverting a left-shifted all-ones vector keeps exactly the low in_size bits.
        mask    = ~({CPEC_DATA_W{1'b1}} << in_size);
        masked  = in_data & mask;
        lshift  = CPEC_SIZE_W'(CPEC_DATA_W) - in_size;
        top     = {masked, {(ACC_W-CPEC_DATA_W){1'b0}}} << lshift;
        aligned = top >> fill;
    end

endmodule

// File: rtl/cpec_bit_packer.sv
// Packs variable-length CPEC/VEC codes MSB-first into W-bit words; flush drains a padded last word.
// Latency: an accepted beat lands in the accumulator the same edge; a full word is presented the next cycle.
// Backpressure: push and pop never overlap; in_ready drops while a full word waits. Option: CPEC_PACKER_STATS_EN.
module cpec_bit_packer
    import cpec_pkg::*;
#(
    parameter int W     = 32,
    parameter int ACC_W = W + 40
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CPEC_DATA_W-1:0] in_data,
    input  logic [CPEC_SIZE_W-1:0] in_size,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic                   out_last,
    output logic                   size_err
`ifdef CPEC_PACKER_STATS_EN
    ,
    output logic [31:0]            bit_count
`endif
);

    localparam int FILL_W = $clog2(ACC_W);
    localparam logic [FILL_W-1:0] W_F = FILL_W'(W);

    cpec_state_t            state_q, state_d;
    logic [ACC_W-1:0]       acc_q;
    logic [FILL_W-1:0]      fill_q;
    logic                   rdy_en_q;
    logic                   size_err_q;

    logic                   word_avail;
    logic                   tail;
    logic                   push;
    logic                   pop;
    logic [CPEC_SIZE_W-1:0] eff_size;
    logic [ACC_W-1:0]       aligned;

    cpec_bit_align #(
        .ACC_W  (ACC_W),
        .FILL_W (FILL_W)
    ) u_align (
        .in_data (in_data),
        .in_size (eff_size),
        .fill    (fill_q),
        .aligned (aligned)
    );

    assign eff_size   = cpec_eff_size(in_size);
    assign word_avail = (fill_q >= W_F);
    // Partial word only leaves during a drain, after all full words are gone.
    assign tail       = (state_q == ST_DRAIN) && (fill_q != '0) && !word_avail;
    assign in_ready   = rdy_en_q && (state_q == ST_RUN) && !word_avail;
    assign out_valid  = word_avail || tail;
    assign out_last   = tail;
    assign out_data   = acc_q[ACC_W-1 -: W];
    assign size_err   = size_err_q;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fill_q == '0 || (tail && out_ready)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Bits below fill are kept zero, so OR-ing the aligned beat is sufficient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            fill_q     <= '0;
            size_err_q <= 1'b0;
        end else begin
            if (push) begin
                acc_q  <= acc_q | aligned;
                fill_q <= fill_q + FILL_W'(eff_size);
                if (in_size > CPEC_SIZE_W'(CPEC_DATA_W)) begin
                    size_err_q <= 1'b1;
                end
            end else if (pop && word_avail) begin
                acc_q  <= acc_q << W;
                fill_q <= fill_q - W_F;
            end else if (pop) begin
                acc_q  <= '0;
                fill_q <= '0;
            end
        end
    end

`ifdef CPEC_PACKER_STATS_EN
    logic [31:0] bit_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_count_q <= '0;
        end else if (push) begin
            bit_count_q <= bit_count_q + 32'(eff_size);
        end
    end

    assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_cpec_bit_packer.sv
// Directed bench for cpec_bit_packer (W=32): packing, backpressure, size errors, flush and reset.
module tb_cpec_bit_packer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [39:0]   in_data;
    logic [5:0]    in_size;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          size_err;
`ifdef CPEC_PACKER_STATS_EN
    logic [31:0]   bit_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpec_bit_packer #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_size   (in_size),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .size_err  (size_err)
`ifdef CPEC_PACKER_STATS_EN
        ,
        .bit_count (bit_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input string tag, input logic [39:0] d, input logic [5:0] s);
        int n = 0;
        in_data  = d;
        in_size  = s;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check({tag, "_timeout"}, 64'(in_ready), 64'd1);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic pop_word(input string tag, input logic [W-1:0] exp_data, input logic exp_last);
        int n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 64'(out_valid), 64'd1);
        end else begin
            check({tag, "_data"}, 64'(out_data), 64'(exp_data));
            check({tag, "_last"}, 64'(out_last), 64'(exp_last));
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic flush_pulse();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_size   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_size_err", 64'(size_err), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("rel_in_ready_high", 64'(in_ready), 64'd1);

        // Four 12-bit codes: one full word, remainder flushed as a padded last word.
        send("b0", 40'hABC, 6'd12);
        send("b1", 40'hDEF, 6'd12);
        send("b2", 40'h123, 6'd12);
        check("full_in_ready", 64'(in_ready), 64'd0);
        pop_word("w0", 32'hABCDEF12, 1'b0);
        send("b3", 40'h456, 6'd12);
        flush_pulse();
        pop_word("w0_tail", 32'h34560000, 1'b1);
        check("w0_back_run", 64'(in_ready), 64'd1);

        // 40-bit code with output stalled, then a single pop leaves 8 bits.
        send("big", 40'hFF_0000_0001, 6'd40);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_data", 64'(out_data), 64'hFF000000);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        pop_word("big_w", 32'hFF000000, 1'b0);
        check("big_after_valid", 64'(out_valid), 64'd0);
        check("big_after_ready", 64'(in_ready), 64'd1);
        flush_pulse();
        pop_word("big_tail", 32'h01000000, 1'b1);

        // Oversize beat is swallowed with an error flag; zero-size beat is a no-op.
        send("oversize", 40'hFF_FFFF_FFFF, 6'd44);
        check("oversize_err", 64'(size_err), 64'd1);
        check("oversize_valid", 64'(out_valid), 64'd0);
        send("zero", 40'hF_FFFF, 6'd0);
        check("zero_valid", 64'(out_valid), 64'd0);
        send("nib", 40'hA, 6'd4);
        flush_pulse();
        pop_word("nib_tail", 32'hA0000000, 1'b1);
        check("err_sticky", 64'(size_err), 64'd1);

        // Flush on an empty packer produces nothing and returns to RUN.
        flush_pulse();
        check("empty_drain_valid", 64'(out_valid), 64'd0);
        check("empty_drain_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("empty_back_valid", 64'(out_valid), 64'd0);
        check("empty_back_ready", 64'(in_ready), 64'd1);

        // Beat coincident with flush is packed, then emitted padded.
        in_data  = 40'hABCDE;
        in_size  = 6'd20;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        pop_word("coinc", 32'hABCDE000, 1'b1);

        // Reset in the middle of a drain.
        send("pre_rst", 40'h12_3456_789A, 6'd40);
        flush_pulse();
        check("drain_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        check("mid_rst_err", 64'(size_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(in_ready), 64'd1);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        send("post", 40'h5, 6'd4);
        flush_pulse();
        pop_word("post_tail", 32'h50000000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
